// File: rtl/cp0_ctrl_pkg.sv
// cp0_ctrl_pkg: shared constants for the CP0 exception controller.
//   - exception codes as they appear in Cause.ExcCode
//   - CP0 register numbers used by mtc0/mfc0
//   - SR and Cause field positions
//   - FSM state encoding
//   - EPC computation helper
package cp0_ctrl_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_NONE = 5'h1F;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2
  } cp0_state_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic bd);
    logic [31:0] base;
    base = bd ? (pc - 32'd4) : pc;
    return base & ~32'h3;
  endfunction

endpackage

// File: rtl/cp0_ctrl_int_sync.sv
// int_sync: two-flop synchronizer for the external interrupt lines.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input lines
//   q     : synchronized lines (second stage)
module int_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_d, meta_q;
  logic [W-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 exception controller beside the M stage.
// Merges the M-stage exception code with synchronized interrupts, holds
// SR/Cause/EPC/PRId, and sequences exception entry and eret return.
//   clk, reset      : clock, asynchronous active-low reset
//   ExcCodeM, PCM,
//   BDM, validM,
//   eretM           : M-stage instruction status
//   HWInt           : asynchronous interrupt lines
//   we, A1, A2, DIn : mtc0 write / mfc0 read port
//   DOut            : read data (combinational)
//   excM            : kill M-stage side effects this cycle (combinational)
//   flush, redirect : one-cycle registered pulse after entry/return
//   NPC             : redirect target
//   EPCOut          : current EPC
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_RUN    | normal operation; requests and mtc0 are evaluated
// ST_ENTER  | flush/redirect to VECTOR; all requests ignored
// ST_RETURN | flush/redirect to EPC; all requests ignored
module cp0_ctrl
  import cp0_ctrl_pkg::*;
#(
  parameter logic [31:0] VECTOR = 32'h0000_4180,
  parameter logic [31:0] PRID   = 32'h4C57_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:2]  ExcCodeM,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic        validM,
  input  logic        eretM,
  input  logic [5:0]  HWInt,
  input  logic        we,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        excM,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] NPC,
  output logic [31:0] EPCOut
);

  // The synchronizer's second stage is Cause.IP itself: reloaded every cycle.
  logic [5:0] ip;

  int_sync #(.W(6)) u_int_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (HWInt),
    .q     (ip)
  );

  cp0_state_e  state_d, state_q;
  logic [5:0]  im_d, im_q;
  logic        exl_d, exl_q;
  logic        ie_d, ie_q;
  logic        bd_d, bd_q;
  logic [4:0]  code_d, code_q;
  logic [31:0] epc_d, epc_q;
  logic        flush_d, flush_q;
  logic        redirect_d, redirect_q;
  logic [31:0] npc_d, npc_q;

  logic in_run, int_req, exc_req;

  always_comb begin
    in_run  = (state_q == ST_RUN);
    int_req = (|(ip & im_q)) & ie_q & ~exl_q & validM;
    exc_req = (ExcCodeM != EXC_NONE) & validM & ~exl_q;
  end

  assign excM = in_run & (int_req | exc_req);

  always_comb begin
    state_d    = ST_RUN;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    code_d     = code_q;
    epc_d      = epc_q;
    flush_d    = 1'b0;
    redirect_d = 1'b0;
    npc_d      = npc_q;

    // ENTER/RETURN fall through to RUN with everything held.
    if (in_run) begin
      if (excM) begin
        // Entry overrides a coincident eret or mtc0.
        exl_d      = 1'b1;
        code_d     = int_req ? EXC_INT : ExcCodeM;
        bd_d       = BDM;
        epc_d      = exc_epc(PCM, BDM);
        state_d    = ST_ENTER;
        flush_d    = 1'b1;
        redirect_d = 1'b1;
        npc_d      = VECTOR;
      end else if (eretM && exl_q) begin
        exl_d      = 1'b0;
        state_d    = ST_RETURN;
        flush_d    = 1'b1;
        redirect_d = 1'b1;
        npc_d      = epc_q;
      end else if (we) begin
        case (A2)
          CP0_SR: begin
            im_d  = DIn[SR_IM_HI:SR_IM_LO];
            exl_d = DIn[SR_EXL];
            ie_d  = DIn[SR_IE];
          end
          CP0_EPC: epc_d = DIn & ~32'h3;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      code_q     <= '0;
      epc_q      <= '0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      npc_q      <= '0;
    end else begin
      state_q    <= state_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      code_q     <= code_d;
      epc_q      <= epc_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      npc_q      <= npc_d;
    end
  end

  always_comb begin
    DOut = '0;
    case (A1)
      CP0_SR: begin
        DOut[SR_IM_HI:SR_IM_LO] = im_q;
        DOut[SR_EXL]            = exl_q;
        DOut[SR_IE]             = ie_q;
      end
      CP0_CAUSE: begin
        DOut[CAUSE_BD]                  = bd_q;
        DOut[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
        DOut[CAUSE_EXC_HI:CAUSE_EXC_LO] = code_q;
      end
      CP0_EPC:  DOut = epc_q;
      CP0_PRID: DOut = PRID;
      default:  DOut = '0;
    endcase
  end

  assign flush    = flush_q;
  assign redirect = redirect_q;
  assign NPC      = npc_q;
  assign EPCOut   = epc_q;

endmodule

// File: tb/tb_cp0_ctrl.sv
module tb_cp0_ctrl;

  localparam logic [31:0] VEC    = 32'h0000_4180;
  localparam logic [31:0] PRID_V = 32'h4C57_0001;
  localparam logic [4:0]  NONE   = 5'h1F;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:2]  ExcCodeM;
  logic [31:0] PCM;
  logic        BDM, validM, eretM, we;
  logic [5:0]  HWInt;
  logic [4:0]  A1, A2;
  logic [31:0] DIn;
  logic [31:0] DOut, NPC, EPCOut;
  logic        excM, flush, redirect;

  always #5 clk = ~clk;

  cp0_ctrl #(.VECTOR(VEC), .PRID(PRID_V)) dut (
    .clk(clk), .reset(reset), .ExcCodeM(ExcCodeM), .PCM(PCM), .BDM(BDM),
    .validM(validM), .eretM(eretM), .HWInt(HWInt), .we(we), .A1(A1),
    .A2(A2), .DIn(DIn), .DOut(DOut), .excM(excM), .flush(flush),
    .redirect(redirect), .NPC(NPC), .EPCOut(EPCOut)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: architectural CP0 state plus a "redirect pending" flag
  // that marks the one cycle after entry/return.
  logic [5:0]  m_im, m_ip, m_hw_seen;
  logic        m_exl, m_ie, m_bd, m_busy;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_npc;

  task automatic model_reset();
    m_im = '0; m_ip = '0; m_hw_seen = '0;
    m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_busy = 1'b0;
    m_code = '0; m_epc = '0; m_npc = '0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    case (a)
      5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13:   return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_code) << 2);
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  // Called just after the negedge with inputs applied; checks, advances the
  // model across the next rising edge, and returns at the following negedge.
  task automatic tick();
    logic intr, exc, take;
    #1;
    if (!reset) model_reset();
    intr = ((m_ip & m_im) != 6'd0) && m_ie && !m_exl && validM;
    exc  = (ExcCodeM != NONE) && validM && !m_exl;
    take = !m_busy && (intr || exc);
    chk("excM",     32'(excM),     32'(take));
    chk("flush",    32'(flush),    32'(m_busy));
    chk("redirect", 32'(redirect), 32'(m_busy));
    chk("NPC",      NPC,           m_npc);
    chk("DOut",     DOut,          exp_read(A1));
    chk("EPCOut",   EPCOut,        m_epc);
    if (reset) begin
      if (m_busy) begin
        m_busy = 1'b0;
      end else if (take) begin
        m_exl  = 1'b1;
        m_code = intr ? 5'd0 : ExcCodeM;
        m_bd   = BDM;
        m_epc  = (BDM ? PCM - 32'd4 : PCM) & 32'hFFFF_FFFC;
        m_busy = 1'b1;
        m_npc  = VEC;
      end else if (eretM && m_exl) begin
        m_exl  = 1'b0;
        m_busy = 1'b1;
        m_npc  = m_epc;
      end else if (we) begin
        if (A2 == 5'd12) begin
          m_im  = DIn[15:10];
          m_exl = DIn[1];
          m_ie  = DIn[0];
        end else if (A2 == 5'd14) begin
          m_epc = DIn & 32'hFFFF_FFFC;
        end
      end
      m_ip      = m_hw_seen;
      m_hw_seen = HWInt;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    ExcCodeM = NONE; PCM = '0; BDM = 1'b0; validM = 1'b0; eretM = 1'b0;
    we = 1'b0; A1 = 5'd12; A2 = 5'd0; DIn = '0;
  endtask

  task automatic do_eret();
    validM = 1'b1; eretM = 1'b1; tick();
    idle(); tick();
  endtask

  logic [4:0] exc_list [5];

  initial begin
    exc_list = '{5'd0, 5'd4, 5'd5, 5'd10, 5'd12};
    model_reset();
    idle(); HWInt = '0; reset = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("rst_npc", NPC, 32'd0);
    reset = 1'b1;
    tick();

    // overflow
    ExcCodeM = 5'd12; validM = 1'b1; PCM = 32'h3010;
    #1 chk("ov_excM", 32'(excM), 32'd1);
    tick();
    idle(); A1 = 5'd14;
    chk("ov_flush", 32'(flush), 32'd1);
    chk("ov_npc", NPC, 32'h4180);
    chk("ov_epc", EPCOut, 32'h3010);
    tick();
    A1 = 5'd13;
    #1 chk("ov_code", (DOut >> 2) & 32'h1F, 32'd12);
    tick();
    A1 = 5'd12;
    #1 chk("ov_exl", (DOut >> 1) & 32'd1, 32'd1);
    tick();

    // return, then a repeat eret with EXL=0
    validM = 1'b1; eretM = 1'b1; tick();
    idle();
    chk("ret_redir", 32'(redirect), 32'd1);
    chk("ret_npc", NPC, 32'h3010);
    #1 chk("ret_exl", DOut & 32'd2, 32'd0);
    tick();
    validM = 1'b1; eretM = 1'b1; tick();
    idle();
    chk("ret2_redir", 32'(redirect), 32'd0);
    tick();

    // delay-slot exception
    ExcCodeM = 5'd4; validM = 1'b1; PCM = 32'h3024; BDM = 1'b1; tick();
    idle(); A1 = 5'd13;
    chk("bd_epc", EPCOut, 32'h3020);
    #1 chk("bd_bit", DOut >> 31, 32'd1);
    tick();
    do_eret();

    // mtc0 coincident with an exception is discarded
    ExcCodeM = 5'd10; validM = 1'b1; PCM = 32'h3100;
    we = 1'b1; A2 = 5'd14; DIn = 32'h5557; tick();
    idle();
    chk("sim_epc", EPCOut, 32'h3100);
    tick();
    do_eret();
    we = 1'b1; A2 = 5'd14; DIn = 32'h5557; tick();
    idle(); A1 = 5'd14;
    #1 chk("mtc0_epc", DOut, 32'h5554);
    tick();

    // interrupt beats a coincident exception, not before the 3rd cycle
    we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0401; tick();
    idle();
    HWInt = 6'h01; validM = 1'b1;
    #1 chk("irq_c1", 32'(excM), 32'd0);
    tick();
    #1 chk("irq_c2", 32'(excM), 32'd0);
    tick();
    ExcCodeM = 5'd5;
    #1 chk("irq_c3", 32'(excM), 32'd1);
    tick();
    idle(); HWInt = '0; A1 = 5'd13;
    #1 chk("irq_code", (DOut >> 2) & 32'h1F, 32'd0);
    chk("irq_flush", 32'(flush), 32'd1);
    tick();
    do_eret();
    we = 1'b1; A2 = 5'd12; DIn = 32'd0; tick();
    idle(); tick();

    // reset during ENTER
    ExcCodeM = 5'd12; validM = 1'b1; PCM = 32'h3200; tick();
    idle();
    chk("rme_flush_pre", 32'(flush), 32'd1);
    reset = 1'b0;
    #1;
    chk("rme_flush", 32'(flush), 32'd0);
    chk("rme_redir", 32'(redirect), 32'd0);
    chk("rme_npc", NPC, 32'd0);
    chk("rme_epc", EPCOut, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 149) != 0);
      ExcCodeM = ($urandom_range(0, 6) == 0) ? exc_list[$urandom_range(0, 4)] : NONE;
      validM   = ($urandom_range(0, 3) != 0);
      eretM    = ($urandom_range(0, 5) == 0);
      BDM      = 1'($urandom_range(0, 1));
      PCM      = $urandom;
      we       = ($urandom_range(0, 3) == 0);
      A2       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      DIn      = $urandom;
      A1       = 5'($urandom_range(10, 16));
      if ($urandom_range(0, 5) == 0) HWInt = 6'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Coprocessor-0 exception controller for the five-stage MIPS pipeline. It sits beside the M stage and takes the exception code that the E-stage checks pass down. It merges that code with synchronized hardware interrupts and holds SR/Cause/EPC/PRId. It sequences exception entry and `eret` return as two-step events: a same-cycle kill of the M-stage instruction, then a registered flush/redirect cycle.

## Interface
Parameters:
- `VECTOR`, 32'h0000_4180, exception handler entry address
- `PRID`, 32'h4C57_0001, PRId read value

Ports:
- `clk` in 1, sole clock, rising edge
- `reset` in 1, asynchronous, active-low; clears all state
- `ExcCodeM` in [6:2], exception code of M-stage instr; `ExcCode_none` when no exception
- `PCM` in 32, PC of M-stage instr
- `BDM` in 1, M-stage instr is in a delay slot
- `validM` in 1, M stage holds a real (non-bubble) instr
- `eretM` in 1, M-stage instr is `eret`
- `HWInt` in 6, asynchronous external interrupt lines
- `we` in 1, `mtc0` write enable (M stage)
- `A1` in 5, read register number
- `A2` in 5, write register number
- `DIn` in 32, write data
- `DOut` out 32, read data (combinational)
- `excM` out 1, kill M-stage side effects this cycle (combinational)
- `flush` out 1, flush F/D/E/M (registered)
- `redirect` out 1, load `NPC` into PC (registered)
- `NPC` out 32, redirect target
- `EPCOut` out 32, current EPC

## Operation
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; read-only to `mtc0`.
  - EPC(14): bits [1:0] always 0.
  - PRId(15): constant `PRID`.
  - Any other `A1` reads 0.
- Interrupt request:
  - `HWInt` passes through a 2-flop synchronizer; the result loads Cause.IP every cycle.
  - `intReq = |(IP & IM) & IE & ~EXL & validM`.
- Synchronous exception request: `excReq = (ExcCodeM != ExcCode_none) & validM & ~EXL`.
- Priority, evaluated in state RUN only: `intReq` > `excReq` > `eretM` (honoured only when EXL=1) > `mtc0` write.
- `excM = (intReq | excReq)` while in RUN; it is 0 in the other states.
- At the edge that takes an exception:
  - EXL <= 1.
  - Cause.ExcCode <= intReq ? `ExcCode_int` (0) : ExcCodeM.
  - Cause.BD <= BDM.
  - EPC <= (BDM ? PCM-4 : PCM) & ~3, computed mod 2^32.
  - The state goes to ENTER. A coincident `mtc0` is discarded.
- FSM:
  - RUN: exception -> ENTER. Otherwise `eretM & EXL` -> RETURN and EXL <= 0. Otherwise apply `mtc0` to SR/EPC.
  - ENTER: `flush=redirect=1`, `NPC=VECTOR`; all requests and writes ignored; -> RUN.
  - RETURN: `flush=redirect=1`, `NPC=EPC`; all requests and writes ignored; -> RUN.
- An `eretM` with EXL=0 is a no-op. `mtc0` to EPC stores `DIn & ~3`.

## Timing
- Reset values:
  - SR, Cause, EPC, and the synchronizer flops = 0.
  - State = RUN.
  - `flush=redirect=excM=0`, `NPC=0`.
  - `DOut`/`EPCOut` reflect the reset registers.
- Reset is asserted asynchronously and released synchronously by its consumers. Asserting reset mid-ENTER or mid-RETURN returns to RUN immediately, with no flush.
- Latency:
  - `excM` is the same cycle as the request.
  - `flush`/`redirect` follow exactly 1 cycle later and last exactly 1 cycle.
  - The handler fetch starts the cycle after that.
- A `HWInt` edge reaches Cause.IP 2 cycles later. It can first raise `intReq` in cycle 3 if enabled and `validM`=1.
- `mtc0` writes are visible on `DOut` the cycle after the edge; there is no read bypass.
- An exception and `eretM` in the same RUN cycle: the exception wins and EXL stays 1.
- An exception request during ENTER/RETURN is dropped. Those instructions are flushed anyway.

## Structure
- `header.v` holds the shared constants:
  - `ExcCode_int`=0, `ExcCode_adel`=4, `ExcCode_ades`=5, `ExcCode_ri`=10, `ExcCode_ov`=12, `ExcCode_none`=5'h1F.
  - CP0 register numbers 12–15.
  - Field position macros for SR and Cause.
  - FSM state encodings RUN/ENTER/RETURN.
- Sub-module `int_sync`: a 6-bit 2-flop synchronizer with asynchronous active-low reset. It is instantiated once.

## Test plan
- Overflow exception:
  - Stimulus: `ExcCodeM=12`, `validM=1`, `PCM=0x3010`, `BDM=0`, SR=0.
  - Response: `excM`=1 that cycle; next cycle `flush=redirect=1`, `NPC=0x4180`; EPC=0x3010, Cause.ExcCode=12, EXL=1.
- Delay-slot exception:
  - Stimulus: `ExcCodeM=4`, `PCM=0x3024`, `BDM=1`.
  - Response: EPC=0x3020, Cause.BD=1.
- Interrupt beats exception:
  - Stimulus: SR=0x0000_0401 via `mtc0`, then `HWInt[0]` rises together with `ExcCodeM=5` three cycles later.
  - Response: ExcCode=0; `intReq` does not fire before the 3rd cycle.
- Return:
  - Stimulus: EXL=1, EPC=0x3010, then `eretM=1`.
  - Response: next cycle `redirect=1`, `NPC=0x3010`, EXL=0; a repeat `eretM` with EXL=0 gives no redirect.
- Simultaneous write:
  - Stimulus: `mtc0` to EPC with `DIn=0x5557` in the same cycle as `ExcCodeM=10`.
  - Response: EPC=PCM; then a separate `mtc0` gives `DOut`(A1=14)=0x5554.
- Reset mid-ENTER:
  - Stimulus: assert `reset` low during the ENTER cycle.
  - Response: `flush=redirect=0` immediately; all registers and outputs return to reset values.
